// File: rtl/tcm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tcm_pkg
// Purpose  : Trellis definition shared by the rate-2/3 4-state TCM codec.
// Revision : 1.0
// ============================================================================
package tcm_pkg;

    localparam int NUM_STATES = 4;

    // State s = {s1,s0} = {v(n-1), v(n-2)}
    function automatic logic [1:0] next_state(input logic [1:0] s, input logic v);
        return {v, s[1]};
    endfunction

    // Returns {y1,y0}
    function automatic logic [1:0] exp_code(input logic [1:0] s, input logic v);
        return {v ^ s[0], s[1]};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return {1'b0, d[0]} + {1'b0, d[1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tcm_acs.sv
`default_nettype none
// ============================================================================
// Module   : tcm_acs
// Purpose  : Add-compare-select and survivor update for one trellis state.
// Revision : 1.0
// ============================================================================
module tcm_acs #(
    parameter int TB_LEN = 16,
    parameter int PM_W   = 6
) (
    input  logic              v,
    input  logic [PM_W-1:0]   pm_a,
    input  logic [PM_W-1:0]   pm_b,
    input  logic [1:0]        bm_a,
    input  logic [1:0]        bm_b,
    input  logic [TB_LEN-2:0] surv_a,
    input  logic [TB_LEN-2:0] surv_b,
    output logic [PM_W-1:0]   pm_new,
    output logic              dec,
    output logic [TB_LEN-1:0] surv_new
);

    logic [PM_W-1:0] cand_a;
    logic [PM_W-1:0] cand_b;

    assign cand_a = pm_a + PM_W'(bm_a);
    assign cand_b = pm_b + PM_W'(bm_b);

    // Strict compare: on a tie the s0=0 predecessor (a) survives
    assign dec      = (cand_b < cand_a);
    assign pm_new   = dec ? cand_b : cand_a;
    assign surv_new = {(dec ? surv_b : surv_a), v};

endmodule
`default_nettype wire

// File: rtl/tcm_dec.sv
`default_nettype none
// ============================================================================
// Module   : tcm_dec
// Purpose  : Hard-decision register-exchange Viterbi decoder, 4-state TCM.
// Revision : 1.0
// ============================================================================
module tcm_dec
    import tcm_pkg::*;
#(
    parameter int TB_LEN = 16,
    parameter int PM_W   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [2:0] y,
    output logic       out_valid,
    output logic [1:0] x_out
);

    localparam int              FILL_W   = $clog2(TB_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TB_LEN);
    localparam logic [PM_W-1:0] PM_HALF  = {1'b1, {(PM_W-1){1'b0}}};
    localparam logic [PM_W-1:0] PM_QUART = {2'b01, {(PM_W-2){1'b0}}};

    logic [PM_W-1:0]       pm       [NUM_STATES];
    logic [TB_LEN-1:0]     surv     [NUM_STATES];
    logic [PM_W-1:0]       pm_acs   [NUM_STATES];
    logic [TB_LEN-1:0]     surv_acs [NUM_STATES];
    logic [NUM_STATES-1:0] dec_unused;
    logic [TB_LEN-1:0]     udl;
    logic [FILL_W-1:0]     fill;
    logic                  norm;
    logic [1:0]            best;

    for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
        localparam logic [1:0] NS = 2'(n);
        localparam logic [1:0] PA = {NS[0], 1'b0};
        localparam logic [1:0] PB = {NS[0], 1'b1};

        tcm_acs #(
            .TB_LEN (TB_LEN),
            .PM_W   (PM_W)
        ) u_acs (
            .v        (NS[1]),
            .pm_a     (pm[PA]),
            .pm_b     (pm[PB]),
            .bm_a     (hamming2(y[1:0], exp_code(PA, NS[1]))),
            .bm_b     (hamming2(y[1:0], exp_code(PB, NS[1]))),
            .surv_a   (surv[PA][TB_LEN-2:0]),
            .surv_b   (surv[PB][TB_LEN-2:0]),
            .pm_new   (pm_acs[n]),
            .dec      (dec_unused[n]),
            .surv_new (surv_acs[n])
        );
    end

    // Min metric stays below PM_HALF and every state is reachable in two
    // steps, so stored values never exceed PM_HALF+PM_QUART+4: no wrap.
    always_comb begin
        norm = 1'b1;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (pm_acs[i] < PM_HALF) norm = 1'b0;
        end
    end

    always_comb begin
        best = 2'd0;
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm[i] < pm[best]) best = 2'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm[i]   <= (i == 0) ? '0 : PM_QUART;
                surv[i] <= '0;
            end
            udl       <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            x_out     <= 2'b00;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                for (int i = 0; i < NUM_STATES; i++) begin
                    pm[i]   <= norm ? (pm_acs[i] - PM_HALF) : pm_acs[i];
                    surv[i] <= surv_acs[i];
                end
                udl <= {udl[TB_LEN-2:0], y[2]};
                if (fill == FILL_MAX) begin
                    out_valid <= 1'b1;
                    x_out     <= {udl[TB_LEN-1], surv[best][TB_LEN-1]};
                end else begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
